hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS core with the attached AES coprocessor.
//  Generates the stall/flush controls for the IF/ID register, the bubble control
//  for ID/EX, and the PC write enable. Covers load-use hazards, taken branches
//  and jumps resolved in EX, and multi-cycle AES instructions.
//  AES instructions run on a start/done handshake and are held in ID until done.
// PARAMETERS
//  TO_W        8    width of the AES timeout counter
//  AES_TIMEOUT 200  max BUSY cycles before forced release (must be < 2**TO_W)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  id_rs        in   5   rs field of the instruction in ID
//  id_rt        in   5   rt field of the instruction in ID
//  id_use_rs    in   1   ID instruction reads rs
//  id_use_rt    in   1   ID instruction reads rt
//  id_aes       in   1   ID instruction is an AES op
//  ex_memread   in   1   EX instruction is a load
//  ex_rt        in   5   destination register of the load in EX
//  branch_taken in   1   taken branch/jump resolved in EX this cycle
//  aes_done     in   1   coprocessor completion pulse
//  pc_write     out  1   PC update enable
//  if_id_stall  out  1   hold the IF/ID register
//  if_id_flush  out  1   clear the IF/ID register
//  id_ex_flush  out  1   insert a bubble into ID/EX
//  aes_start    out  1   one-cycle start pulse to the coprocessor
//  aes_busy     out  1   state == BUSY
//  aes_err      out  1   sticky timeout flag
//  stall_cnt    out  32  saturating count of cycles with pc_write==0
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, timeout cnt=0, aes_err=0, stall_cnt=0.
//   All control outputs are 0 except pc_write=1.
//  Control outputs are combinational from state and inputs (same-cycle effect).
//  Registers (state, cnt, aes_err, stall_cnt) update on posedge clk.
//  lu = ex_memread & ex_rt!=0 &
//       ((id_use_rs & ex_rt==id_rs) | (id_use_rt & ex_rt==id_rt)).
//  Priority, highest first:
//   1. branch_taken: if_id_flush=1, id_ex_flush=1, pc_write=1, aes_start=0.
//      Flushes a pending AES/lu in ID. Applies in any state; it cannot occur in
//      BUSY because EX holds bubbles.
//   2. lu (state IDLE or RELEASE): pc_write=0, if_id_stall=1, id_ex_flush=1 for
//      the cycle; exactly one bubble. AES start is deferred until lu clears.
//   3. IDLE & id_aes: aes_start=1, pc_write=0, if_id_stall=1, id_ex_flush=1;
//      next state BUSY, cnt<=0.
//  FSM:
//   IDLE    -> BUSY on case 3 only.
//   BUSY    pc_write=0, if_id_stall=1, id_ex_flush=1; cnt<=cnt+1.
//           aes_done=1 -> RELEASE (the done cycle is still stalled).
//           Else if cnt==AES_TIMEOUT-1 -> RELEASE and aes_err<=1.
//   RELEASE no stall from AES (lu and branch rules still apply); the AES
//           instruction advances to EX. id_aes is ignored here (no retrigger).
//           -> IDLE next cycle.
//  aes_done is ignored outside BUSY. aes_start is high for at most one cycle
//  per AES instruction.
//  stall_cnt += 1 in every cycle with pc_write==0; saturates at 32'hFFFF_FFFF.
//  aes_err is cleared only by reset.
//  Reset asserted mid-BUSY returns to IDLE immediately. The coprocessor must be
//  reset by the same rst.
// TESTING
//  T1 load-use: ex_memread=1, ex_rt=5, id_rs=5, id_use_rs=1 -> exactly 1 cycle
//     of pc_write=0, if_id_stall=1, id_ex_flush=1; stall_cnt +1.
//  T2 rt=0: same as T1 with ex_rt=0 -> no stall; id_use_rs=0 also -> no stall.
//  T3 AES: id_aes=1, aes_done 4 cycles after aes_start -> aes_start 1 cycle;
//     pc_write=0 for 5 cycles; RELEASE cycle with id_aes=1 gives no new start.
//  T4 branch vs AES/lu: branch_taken=1 with id_aes=1 and lu=1 in one cycle ->
//     if_id_flush=1, id_ex_flush=1, pc_write=1, aes_start=0, state stays IDLE.
//  T5 timeout: id_aes=1, aes_done never asserted -> after 200 BUSY cycles
//     aes_err=1 and state RELEASE then IDLE; a later aes_done pulse is ignored.
//  T6 reset: assert rst=0 in BUSY cycle 3 -> outputs at reset values at once;
//     after release, id_aes=1 issues a fresh aes_start.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller.
// The slave modport is the controller's view; the master modport is the pipeline's view.
interface hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_aes;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic        branch_taken;
    logic        aes_done;
    logic        pc_write;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        aes_start;
    logic        aes_busy;
    logic        aes_err;
    logic [31:0] stall_cnt;

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_aes,
        input  ex_memread, ex_rt, branch_taken, aes_done,
        output pc_write, if_id_stall, if_id_flush, id_ex_flush,
        output aes_start, aes_busy, aes_err, stall_cnt
    );

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_aes,
        output ex_memread, ex_rt, branch_taken, aes_done,
        input  pc_write, if_id_stall, if_id_flush, id_ex_flush,
        input  aes_start, aes_busy, aes_err, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline with the AES coprocessor:
// load-use bubbles, EX-resolved branch flushes, and AES start/done hold with timeout.
module hazard_ctrl #(
    parameter int unsigned TO_W        = 8,
    parameter int unsigned AES_TIMEOUT = 200
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(AES_TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [TO_W-1:0] cnt;
    logic            lu;
    logic            start;
    logic            timeout;

    always_comb begin
        lu = bus.ex_memread && (bus.ex_rt != 5'd0) &&
             ((bus.id_use_rs && (bus.ex_rt == bus.id_rs)) ||
              (bus.id_use_rt && (bus.ex_rt == bus.id_rt)));
    end

    assign timeout = (cnt == TO_LAST);

    always_comb begin
        state_nxt       = state;
        start           = 1'b0;
        bus.pc_write    = 1'b1;
        bus.if_id_stall = 1'b0;
        bus.if_id_flush = 1'b0;
        bus.id_ex_flush = 1'b0;

        case (state)
            IDLE: begin
                // A branch flush or a pending load-use bubble defers the AES start.
                if (!bus.branch_taken && !lu && bus.id_aes) begin
                    start     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.aes_done || timeout)
                    state_nxt = RELEASE;
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (bus.branch_taken) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (start || lu || state == BUSY) begin
            bus.pc_write    = 1'b0;
            bus.if_id_stall = 1'b1;
            bus.id_ex_flush = 1'b1;
        end

        bus.aes_start = start;
        bus.aes_busy  = (state == BUSY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.aes_err   <= 1'b0;
            bus.stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (start)
                cnt <= '0;
            else if (state == BUSY)
                cnt <= cnt + 1'b1;
            if (state == BUSY && !bus.aes_done && timeout)
                bus.aes_err <= 1'b1;
            if (!bus.pc_write && bus.stall_cnt != '1)
                bus.stall_cnt <= bus.stall_cnt + 32'd1;
        end
    end

endmodule
